// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters for the RV32 pipeline.
// IF looks up combinationally; MEM trains the table, flags mispredicts and bumps stats.
module branch_predictor #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int STAT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   fetch_pc,
   output logic              pred_taken,
   output logic [XLEN-1:0]   pred_target,
   input  logic              upd_valid,
   input  logic [XLEN-1:0]   upd_pc,
   input  logic              upd_is_branch,
   input  logic              upd_taken,
   input  logic [XLEN-1:0]   upd_target,
   input  logic              upd_pred_taken,
   input  logic [XLEN-1:0]   upd_pred_target,
   input  logic              flush,
   output logic              mispredict,
   output logic [STAT_W-1:0] stat_updates,
   output logic [STAT_W-1:0] stat_mispredicts
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - 2 - IDX_W;

   logic [ENTRIES-1:0] r_valid;
   logic [ENTRIES-1:0] r_isJump;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [XLEN-1:0]    r_target [ENTRIES];
   logic [1:0]         r_ctr    [ENTRIES];
   logic [STAT_W-1:0]  r_statUpd;
   logic [STAT_W-1:0]  r_statMis;

   logic [IDX_W-1:0] w_fIdx;
   logic [TAG_W-1:0] w_fTag;
   logic             w_fHit;
   logic [IDX_W-1:0] w_uIdx;
   logic [TAG_W-1:0] w_uTag;
   logic             w_uHit;
   logic [1:0]       w_uCtr;

   assign w_fIdx = fetch_pc[IDX_W+1:2];
   assign w_fTag = fetch_pc[XLEN-1:IDX_W+2];
   assign w_fHit = r_valid[w_fIdx] && (r_tag[w_fIdx] == w_fTag);

   assign pred_taken  = w_fHit && (r_isJump[w_fIdx] || r_ctr[w_fIdx][1]);
   assign pred_target = pred_taken ? r_target[w_fIdx] : fetch_pc + XLEN'(4);

   assign w_uIdx = upd_pc[IDX_W+1:2];
   assign w_uTag = upd_pc[XLEN-1:IDX_W+2];
   assign w_uHit = r_valid[w_uIdx] && (r_tag[w_uIdx] == w_uTag);
   assign w_uCtr = r_ctr[w_uIdx];

   assign mispredict = upd_valid &&
                       ((upd_pred_taken != upd_taken) ||
                        (upd_taken && (upd_pred_target != upd_target)));

   // Flush takes priority over training so that no entry survives a fence.i.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid  <= '0;
         r_isJump <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b01;
         end
      end else if (flush) begin
         r_valid <= '0;
      end else if (upd_valid) begin
         if (w_uHit) begin
            if (upd_is_branch) begin
               if (upd_taken) begin
                  if (w_uCtr != 2'b11) r_ctr[w_uIdx] <= w_uCtr + 2'b01;
                  r_target[w_uIdx] <= upd_target;
               end else if (w_uCtr != 2'b00) begin
                  r_ctr[w_uIdx] <= w_uCtr - 2'b01;
               end
            end else begin
               r_ctr[w_uIdx]    <= 2'b11;
               r_target[w_uIdx] <= upd_target;
            end
         end else if (upd_taken) begin
            r_valid[w_uIdx]  <= 1'b1;
            r_tag[w_uIdx]    <= w_uTag;
            r_target[w_uIdx] <= upd_target;
            r_isJump[w_uIdx] <= ~upd_is_branch;
            r_ctr[w_uIdx]    <= upd_is_branch ? 2'b10 : 2'b11;
         end
      end
   end

   // Statistics saturate at all-ones and keep counting through a flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_statUpd <= '0;
         r_statMis <= '0;
      end else begin
         if (upd_valid && (r_statUpd != '1)) r_statUpd <= r_statUpd + STAT_W'(1);
         if (mispredict && (r_statMis != '1)) r_statMis <= r_statMis + STAT_W'(1);
      end
   end

   assign stat_updates     = r_statUpd;
   assign stat_mispredicts = r_statMis;

endmodule
